// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage: datapath widths, the
// occupancy state encoding and the packed entry stored in each slot.
// Optional feature macro: ALU_RESULT_ZERO_EN adds a per-entry zero flag.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 64;
    localparam int REG_IDX_WIDTH  = 5;

    // Occupancy of the stage; the encoding doubles as the count output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // One buffered ALU result with its destination register.
    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] result;
        logic [REG_IDX_WIDTH-1:0]  rd;
`ifdef ALU_RESULT_ZERO_EN
        logic                      zero;
`else
        // no zero flag stored when the feature is disabled
`endif
    } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
// Bundles the upstream (ALU side) and downstream (register-file side)
// valid/ready handshakes of the ALU result stage, plus its occupancy count.
//   in_valid/in_ready/in_result/in_rd     : ALU -> stage
//   out_valid/out_ready/out_result/out_rd : stage -> register file
//   out_zero                              : head result is zero
//                                           (only with ALU_RESULT_ZERO_EN)
//   count                                 : occupancy 0..2
// Modports: master = environment (ALU + register file), slave = the stage.
// ---------------------------------------------------------------------------
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int RD_WIDTH   = REG_IDX_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_result;
    logic [RD_WIDTH-1:0]   in_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [RD_WIDTH-1:0]   out_rd;
`ifdef ALU_RESULT_ZERO_EN
    logic                  out_zero;
`else
    // out_zero is absent when the feature is disabled
`endif
    logic [1:0]            count;

    modport master (
        output in_valid, in_result, in_rd, out_ready,
`ifdef ALU_RESULT_ZERO_EN
        input  out_zero,
`endif
        input  in_ready, out_valid, out_result, out_rd, count
    );

    modport slave (
        input  in_valid, in_result, in_rd, out_ready,
`ifdef ALU_RESULT_ZERO_EN
        output out_zero,
`endif
        output in_ready, out_valid, out_result, out_rd, count
    );

endinterface

// File: rtl/alu_result_slot.sv
// ---------------------------------------------------------------------------
// alu_result_slot
// A single enable-loaded entry register with asynchronous active-high reset.
//   clk, reset : clock and async reset (clears the entry to zero)
//   load       : capture entry_d at the rising edge
//   entry_d    : next entry value
//   entry_q    : stored entry
// ---------------------------------------------------------------------------
module alu_result_slot
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  alu_entry_t entry_d,
    output alu_entry_t entry_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else if (load) begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Two-entry skid buffer between the combinational ALU and the register-file
// write port. Results are held in FIFO order while writeback stalls and are
// discarded on flush. All outputs come straight from flops.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   flush : synchronous; empties the stage this cycle, drops any input
//   stage : alu_result_stage_if.slave (in_* / out_* handshakes, count,
//           out_zero when ALU_RESULT_ZERO_EN is defined)
// Optional feature macro: ALU_RESULT_ZERO_EN.
// ---------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    alu_result_stage_if.slave  stage
);

    occ_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       accept, drain;
    logic       head_load, tail_load, head_from_tail;
    alu_entry_t in_entry, head_d, head_q, tail_q;

    assign accept = stage.in_valid && in_ready_q;
    assign drain  = out_valid_q && stage.out_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.result = stage.in_result;
        in_entry.rd     = stage.in_rd;
`ifdef ALU_RESULT_ZERO_EN
        in_entry.zero   = (stage.in_result == '0);
`else
        // nothing extra to capture
`endif
    end

    // Occupancy FSM: picks which slot loads and whether head refills from tail.
    // A simultaneous accept and drain in ONE writes straight into head, so the
    // tail slot is only ever used while the head is stalled.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        tail_load      = 1'b0;
        head_from_tail = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    head_load = 1'b1;
                end else if (accept) begin
                    tail_load = 1'b1;
                    state_d   = FULL;
                end else if (drain) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    head_load      = 1'b1;
                    head_from_tail = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush wins over everything; slot contents become don't-care.
        if (flush) begin
            state_d   = EMPTY;
            head_load = 1'b0;
            tail_load = 1'b0;
        end
        head_d      = head_from_tail ? tail_q : in_entry;
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Handshake flags are registered from the next state so that no path
    // exists from out_ready to in_ready or from in_* to out_*.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    alu_result_slot u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (head_load),
        .entry_d (head_d),
        .entry_q (head_q)
    );

    alu_result_slot u_tail (
        .clk     (clk),
        .reset   (reset),
        .load    (tail_load),
        .entry_d (in_entry),
        .entry_q (tail_q)
    );

    assign stage.in_ready   = in_ready_q;
    assign stage.out_valid  = out_valid_q;
    assign stage.out_result = head_q.result;
    assign stage.out_rd     = head_q.rd;
    assign stage.count      = state_q;
`ifdef ALU_RESULT_ZERO_EN
    assign stage.out_zero   = head_q.zero;
`else
    // out_zero is not driven when the feature is disabled
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Directed testbench for alu_result_stage. A driver issues one input pattern
// per clock and pushes accepted results into an expected queue; a separate
// monitor pops and compares whenever the stage delivers a result.
// Optional feature macro: ALU_RESULT_ZERO_EN enables the zero-flag test.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        zero;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   model_count = 0;
    exp_t exp_q[$];

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .stage (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle starting just after a rising edge; check occupancy
    // against the bench model at the falling edge, then advance the model.
    task automatic applyStimulus(input logic valid, input logic [63:0] result,
                                 input logic [4:0] rd, input logic oready,
                                 input logic fl);
        logic acc;
        logic drn;
        exp_t e;
        bus.in_valid  = valid;
        bus.in_result = result;
        bus.in_rd     = rd;
        bus.out_ready = oready;
        flush         = fl;
        @(negedge clk);
        checkOutput("count", 64'(bus.count), 64'(model_count));
        checkOutput("in_ready", 64'(bus.in_ready), 64'(model_count != 2));
        checkOutput("out_valid", 64'(bus.out_valid), 64'(model_count != 0));
        acc = valid && (model_count != 2);
        drn = oready && (model_count != 0);
        if (acc && !fl) begin
            e.result = result;
            e.rd     = rd;
            e.zero   = (result == 64'd0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            model_count = model_count + int'(acc) - int'(drn);
        end
        #1;
    endtask

    // Monitor: a delivery happens at the next rising edge whenever
    // out_valid and out_ready are both high at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got result 0x%0h rd %0d, expected no output",
                             bus.out_result, bus.out_rd);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_result", bus.out_result, e.result);
                    checkOutput("out_rd", 64'(bus.out_rd), 64'(e.rd));
`ifdef ALU_RESULT_ZERO_EN
                    checkOutput("out_zero", 64'(bus.out_zero), 64'(e.zero));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset_count", 64'(bus.count), 64'd0);
        checkOutput("reset_out_result", bus.out_result, 64'd0);
        checkOutput("reset_out_rd", 64'(bus.out_rd), 64'd0);
`ifdef ALU_RESULT_ZERO_EN
        checkOutput("reset_out_zero", 64'(bus.out_zero), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single result with immediate drain");
        applyStimulus(1'b1, 64'hFFFF_0000_FFFF_0000, 5'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] stall with three back-to-back offers");
        applyStimulus(1'b1, 64'hAAAA_0000_0000_0001, 5'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hBBBB_0000_0000_0002, 5'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hCCCC_0000_0000_0003, 5'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hCCCC_0000_0000_0003, 5'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'hCCCC_0000_0000_0003, 5'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] continuous stream, rd=0 included");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 64'(i + 1) * 64'h0101_0101_0101_0101, 5'(i), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] flush while full with a coincident offer");
        applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0010, 5'd16, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0011, 5'd17, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_0000_1234, 5'd9, 1'b0, 1'b1);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] flush coinciding with a drain");
        applyStimulus(1'b1, 64'h5555_5555_5555_5555, 5'd21, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_0000_1234, 5'd9, 1'b1, 1'b1);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

`ifdef ALU_RESULT_ZERO_EN
        $display("[TB] zero flag follows its entry");
        applyStimulus(1'b1, 64'h00FF & 64'hFF00, 5'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h0F0F & 64'h0F00, 5'd11, 1'b0, 1'b0);
        checkOutput("head_zero_first", 64'(bus.out_zero), 64'd1);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("head_zero_second", 64'(bus.out_zero), 64'd0);
        checkOutput("head_result_second", bus.out_result, 64'h0F00);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
`endif

        $display("[TB] asynchronous reset with two entries held");
        applyStimulus(1'b1, 64'h1357_9BDF_0000_0001, 5'd12, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h2468_ACE0_0000_0002, 5'd13, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checkOutput("pre_reset_count", 64'(bus.count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("async_count", 64'(bus.count), 64'd0);
        checkOutput("async_out_result", bus.out_result, 64'd0);
        checkOutput("async_out_rd", 64'(bus.out_rd), 64'd0);
`ifdef ALU_RESULT_ZERO_EN
        checkOutput("async_out_zero", 64'(bus.out_zero), 64'd0);
`endif
        exp_q.delete();
        model_count = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] traffic after reset");
        applyStimulus(1'b1, 64'h0F0F_F0F0_0F0F_F0F0, 5'd31, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Two-entry skid buffer between the 64-bit ALU operation units (and, or, add, shift, ...) and the register-file write port. Each ALU result is captured together with its destination register index under a valid/ready handshake. Results are held in order while writeback is stalled, and are dropped on a pipeline flush. It is the first registered stage downstream of the combinational ALU.

## Interface
- DATA_WIDTH, 64, width of ALU result
- RD_WIDTH, 5, width of destination register index
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  synchronous; discards all held entries this cycle
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept; registered, equals (count != 2)
- in_result  input  DATA_WIDTH  ALU result (e.g. bitwise AND output)
- in_rd  input  RD_WIDTH  destination register index
- out_valid  output  1  head entry valid; equals (count != 0)
- out_ready  input  1  register file accepts head entry
- out_result  output  DATA_WIDTH  head entry result
- out_rd  output  RD_WIDTH  head entry destination index
- out_zero  output  1  head result == 0 (only with ALU_RESULT_ZERO_EN)
- count  output  2  occupancy, 0..2

## Operation
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- State machine on occupancy: EMPTY (0), ONE (1), FULL (2). Entries are stored in two slots, head and tail. The head always drives the out_* ports directly from flops.
- Accept: in_valid && in_ready at the clock edge.
- Drain: out_valid && out_ready at the clock edge.
- EMPTY transitions:
  - accept → ONE; entry is written into head.
- ONE transitions:
  - accept only → FULL; entry is written into tail.
  - drain only → EMPTY.
  - accept and drain together → ONE; the new entry is written into head.
- FULL transitions:
  - drain → ONE; tail moves to head.
  - accept is impossible because in_ready = 0.
- flush: the next state is EMPTY regardless of accept or drain in the same cycle.
  - An input offered in the flush cycle is dropped, even if in_valid && in_ready.
  - A drain completing in the flush cycle still counts as delivered to the consumer.
- Data in empty slots is don't-care. Verification must check out_result and out_rd only while out_valid = 1.
- Ordering: strict FIFO. No entry is duplicated or reordered.
- in_rd = 0 is passed through unchanged. Suppressing x0 writes is the register file's job.

## Timing
- Reset values: out_valid 0, in_ready 1, count 0, out_result 0, out_rd 0, out_zero 0.
- Latency: an entry accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when it was ONE with a simultaneous drain.
- Throughput: one result per cycle while out_ready stays high.
- Stall behaviour:
  - With out_ready low, the stage absorbs at most 2 results, then in_ready drops.
  - in_ready rises one cycle after the first drain.
- No combinational path from out_ready to in_ready, or from in_* to out_*. All outputs come from flops.
- If reset is asserted mid-transfer, the stage goes EMPTY immediately and asynchronously. Any transfer at a coincident edge is lost.

## Configuration
- Macro: ALU_RESULT_ZERO_EN.
- Defined:
  - The stage stores a 1-bit zero flag per slot, computed at capture as (in_result == 0).
  - out_zero presents the head slot's flag.
  - The flag moves with its entry.
- Undefined:
  - The out_zero port is absent.
  - No flag storage is implemented.
  - All other behaviour is identical.

## Structure
- Shared package alu_pkg:
  - localparams ALU_DATA_WIDTH = 64 and REG_IDX_WIDTH = 5.
  - Occupancy state typedef with values EMPTY, ONE, FULL.
  - A packed entry struct holding result, rd and the optional zero flag.
- One sub-module: alu_result_slot. It is a single enable-loaded entry register with async reset, instantiated for head and tail.
- The control FSM and the slot muxing live in the top module.

## Test plan
- Reset, then offer one result 0xFFFF_0000_FFFF_0000 with rd=7 and out_ready=1 → out_valid high the next cycle with the same data and rd; count returns to 0 after the drain.
- Hold out_ready=0 and offer 3 back-to-back results A, B, C → in_ready low after A and B (count=2); C is not accepted. Raise out_ready → A, then B, then C delivered in order; in_ready rises one cycle after the first drain.
- Stream 16 results with out_ready=1 and in_valid=1 continuously → one result per cycle; count stays at 1; order preserved.
- Reach FULL, then assert flush together with in_valid and data 0x1234 → count=0 and out_valid=0 the next cycle; 0x1234 never appears on the output.
- With ALU_RESULT_ZERO_EN defined, offer the ANDs 0x00FF & 0xFF00 and 0x0F0F & 0x0F00 → head out_zero=1 for the first result (result 0x0000), then out_zero=0 for the second (result 0x0F00).
- Assert reset asynchronously mid-stream, between edges, with count=2 → outputs go to reset values immediately, before the next edge.
